// File: rtl/score_pkg.sv
// Shared definitions for the score datapath (adder, deductor, tracker).
package score_pkg;

  // Default score / penalty width in bits.
  localparam int SCORE_W = 5;

  // Sequencer states for the bit-serial score units.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/score_deduct_if.sv
// Bus between the penalty/event logic (master) and score_deduct (slave).
//
// Handshake: the master raises start with A/B valid; the request is taken
// at a rising edge where the unit is idle, E=1 and stop=0 (busy goes high
// after that edge). start seen while busy or done is dropped, not queued.
// done is a one-cycle pulse (while E=1) marking out/underflow valid; out and
// underflow then hold until the next completion, stop, or reset.
// state is a read-only debug view of the sequencer.
interface score_deduct_if
  import score_pkg::*;
#(
  parameter int WIDTH = SCORE_W
) ();

  logic             E;
  logic             stop;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             underflow;
  state_t           state;

  modport master (
    output E, stop, start, A, B,
    input  busy, done, out, underflow, state
  );

  modport slave (
    input  E, stop, start, A, B,
    output busy, done, out, underflow, state
  );

endinterface

// File: rtl/score_deduct_sub_bit.sv
// One-bit full subtractor cell; mirror of the adder's full-adder cell.
module sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow-out of a - b - bin.
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/score_deduct.sv
// Bit-serial, LSB-first score subtractor: out = A - B over WIDTH cycles.
// Optional macro SCORE_DEDUCT_SAT_EN: when defined, an underflowing result
// is floored at zero instead of wrapping modulo 2^WIDTH.
module score_deduct
  import score_pkg::*;
#(
  parameter int WIDTH = SCORE_W
) (
  input  logic         clk,
  input  logic         Reset,
  score_deduct_if.slave bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_out;
  logic [CW-1:0]    r_cnt;
  logic             r_bw;
  logic             r_uf;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_out_load;

  // Single subtractor cell reused every step on the current LSBs.
  sub_bit u_sub_bit (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_bw),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last     = (r_cnt == LAST);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

`ifdef SCORE_DEDUCT_SAT_EN
  assign w_out_load = w_bout ? '0 : w_res_next;
`else
  assign w_out_load = w_res_next;
`endif

  // State register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: stop overrides, E=0 freezes.
  always_comb begin
    w_next = r_state;
    if (bus.stop) begin
      w_next = IDLE;
    end else if (bus.E) begin
      case (r_state)
        IDLE:    if (bus.start) w_next = SUB;
        SUB:     if (w_last)    w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Datapath: capture operands, shift one bit per step, load result at the end.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_bw  <= 1'b0;
      r_out <= '0;
      r_uf  <= 1'b0;
    end else if (bus.stop) begin
      r_cnt <= '0;
      r_bw  <= 1'b0;
      r_out <= '0;
      r_uf  <= 1'b0;
    end else if (bus.E) begin
      if (r_state == IDLE && bus.start) begin
        r_a   <= bus.A;
        r_b   <= bus.B;
        r_res <= '0;
        r_cnt <= '0;
        r_bw  <= 1'b0;
      end else if (r_state == SUB) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_res <= w_res_next;
        r_bw  <= w_bout;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_out <= w_out_load;
          r_uf  <= w_bout;
        end
      end
    end
  end

  assign bus.busy      = (r_state == SUB);
  assign bus.done      = (r_state == DONE);
  assign bus.out       = r_out;
  assign bus.underflow = r_uf;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_score_deduct.sv
// Self-checking bench for score_deduct (directed vectors, scoreboard queue).
module tb_score_deduct;
  import score_pkg::*;

  localparam int W = 5;

  logic clk;
  logic Reset;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [W:0] exp_q[$];

  score_deduct_if #(.WIDTH(W)) bus ();

  score_deduct #(.WIDTH(W)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d exp %0d", name, got, exp);
    end
  endtask

  // Issue a start with A/B; optionally push the expected {underflow,out}.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push, input logic [W-1:0] eo,
                          input logic eu);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    if (push) exp_q.push_back({eu, eo});
    @(negedge clk);
    bus.start = 1'b0;
    // Operands may move after accept without effect.
    bus.A = W'($urandom_range(0, 31));
    bus.B = W'($urandom_range(0, 31));
  endtask

  // Count negedges until done is seen with E=1; bounded.
  task automatic wait_done(input int start_cycles, input int budget,
                           output int cycles);
    cycles = start_cycles;
    while (!(bus.done && bus.E) && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (!(bus.done && bus.E)) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles exp done", cycles);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eo, input logic eu,
                        input string name);
    int cyc;
    start_op(a, b, 1'b1, eo, eu);
    check({name, "_busy"}, int'(bus.busy), 1);
    wait_done(0, 40, cyc);
    check({name, "_latency"}, cyc, W);
    @(negedge clk);
    check({name, "_idle"}, int'(bus.state), int'(IDLE));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (Reset && bus.done && bus.E) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got out=%0d uf=%0d exp no done",
                 bus.out, bus.underflow);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if (bus.out !== e[W-1:0] || bus.underflow !== e[W]) begin
          errors++;
          $display("FAIL result: got out=%0d uf=%0d exp out=%0d uf=%0d",
                   bus.out, bus.underflow, e[W-1:0], e[W]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int d0;

    Reset     = 1'b0;
    bus.E     = 1'b1;
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    check("reset_out",   int'(bus.out), 0);
    check("reset_uf",    int'(bus.underflow), 0);
    check("reset_busy",  int'(bus.busy), 0);
    check("reset_done",  int'(bus.done), 0);
    check("reset_state", int'(bus.state), int'(IDLE));
    Reset = 1'b1;
    @(negedge clk);

    // Basic subtraction.
    run_op(5'd20, 5'd7, 5'd13, 1'b0, "basic");

    // Underflow: 3 - 9.
`ifdef SCORE_DEDUCT_SAT_EN
    run_op(5'd3, 5'd9, 5'd0, 1'b1, "uflow");
`else
    run_op(5'd3, 5'd9, 5'd26, 1'b1, "uflow");
`endif

    // Asynchronous reset in the middle of an operation.
    start_op(5'd20, 5'd7, 1'b0, '0, 1'b0);
    @(negedge clk);
    #2 Reset = 1'b0;
    #1;
    check("arst_out",  int'(bus.out), 0);
    check("arst_uf",   int'(bus.underflow), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    @(negedge clk);
    Reset = 1'b1;
    run_op(5'd5, 5'd0, 5'd5, 1'b0, "after_rst");

    // Abort with stop on the third SUB cycle.
    d0 = done_cnt;
    start_op(5'd31, 5'd1, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("abort_state", int'(bus.state), int'(IDLE));
    check("abort_out",   int'(bus.out), 0);
    check("abort_busy",  int'(bus.busy), 0);
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_op(5'd10, 5'd10, 5'd0, 1'b0, "post_abort");

    // stop and start together in IDLE: nothing accepted.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    bus.A     = 5'd9;
    bus.B     = 5'd2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("stop_start_busy", int'(bus.busy), 0);

    // Enable stall mid-SUB plus an ignored start while busy.
    d0 = done_cnt;
    start_op(5'd16, 5'd15, 1'b1, 5'd1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 5'd3;
    bus.B     = 5'd1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.E     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.E = 1'b1;
    wait_done(4, 40, cyc);
    check("stall_latency", cyc, W + 2);
    repeat (10) @(negedge clk);
    check("stall_one_done", done_cnt - d0, 1);

    // Boundaries.
    run_op(5'd0,  5'd0,  5'd0, 1'b0, "zero_zero");
    run_op(5'd31, 5'd31, 5'd0, 1'b0, "max_max");
`ifdef SCORE_DEDUCT_SAT_EN
    run_op(5'd0, 5'd31, 5'd0, 1'b1, "zero_max");
`else
    run_op(5'd0, 5'd31, 5'd1, 1'b1, "zero_max");
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
